// File: rtl/kuznechik_decrypt_core_if.sv
// Bus between the Kuznechik decrypt core and its surroundings.
// master: key expansion / block source side (drives keys, keys_valid, start, data_in)
// slave : decrypt core (drives ready, done, data_out)
//   keys_valid     round keys stable
//   key_1..key_10  round keys K1..K10
//   start/data_in  one-cycle request with ciphertext block (a15 = [127:120])
//   ready          core idle, start will be accepted
//   done/data_out  one-cycle pulse with plaintext, data_out held until next done
interface kuznechik_decrypt_core_if;
   localparam int unsigned BLOCK_W = 128;

   logic               keys_valid;
   logic [BLOCK_W-1:0] key_1;
   logic [BLOCK_W-1:0] key_2;
   logic [BLOCK_W-1:0] key_3;
   logic [BLOCK_W-1:0] key_4;
   logic [BLOCK_W-1:0] key_5;
   logic [BLOCK_W-1:0] key_6;
   logic [BLOCK_W-1:0] key_7;
   logic [BLOCK_W-1:0] key_8;
   logic [BLOCK_W-1:0] key_9;
   logic [BLOCK_W-1:0] key_10;
   logic               start;
   logic [BLOCK_W-1:0] data_in;
   logic               ready;
   logic               done;
   logic [BLOCK_W-1:0] data_out;

   modport master (
      output keys_valid, key_1, key_2, key_3, key_4, key_5,
             key_6, key_7, key_8, key_9, key_10, start, data_in,
      input  ready, done, data_out
   );

   modport slave (
      input  keys_valid, key_1, key_2, key_3, key_4, key_5,
             key_6, key_7, key_8, key_9, key_10, start, data_in,
      output ready, done, data_out
   );
endinterface

// File: rtl/kuznechik_decrypt_core.sv
// Iterative Kuznechik (GOST R 34.12-2015) 128-bit block decryptor.
// D = X[K1] S^-1 L^-1 X[K2] ... X[K9] S^-1 L^-1 X[K10] (c)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    kuznechik_decrypt_core_if.slave (keys, start/data_in, ready/done/data_out)
// Parameter CHECK_KEYS: 1 = start ignored and busy work aborted while keys_valid=0.
// Build macro KUZ_FAST_LINV_EN: whole L^-1 in one cycle (latency 19) instead of
// one R^-1 step per cycle (latency 154).
module kuznechik_decrypt_core #(
   parameter int unsigned CHECK_KEYS = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   kuznechik_decrypt_core_if.slave bus
);
   localparam int unsigned BLOCK_W = 128;
   localparam int unsigned CNT_W   = 4;
   // l() coefficients, byte j multiplies x_j
   localparam logic [BLOCK_W-1:0] L_COEF = 128'h94_20_85_10_C2_C0_01_FB_01_C0_C2_10_85_20_94_01;

   typedef enum logic [1:0] {IDLE, LINV, SXOR} state_t;

   state_t             state_q, state_d;
   logic [BLOCK_W-1:0] st_q, st_d;
   logic [CNT_W-1:0]   rnd_q, rnd_d;
   logic [CNT_W-1:0]   step_q, step_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic [BLOCK_W-1:0] data_out_q, data_out_d;
   logic [BLOCK_W-1:0] rkey_c;
   logic [BLOCK_W-1:0] sxor_c;
   logic [BLOCK_W-1:0] linv_c;
   logic               key_ok_c;
   logic               abort_c;

   // GF(2^8) multiply modulo x^8+x^7+x^6+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'd0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
      end
      return p;
   endfunction

   // R^-1: shift left one byte, new low byte is l(a14..a0, a15)
   function automatic logic [BLOCK_W-1:0] r_inv(input logic [BLOCK_W-1:0] a);
      logic [BLOCK_W-1:0] x;
      logic [7:0]         acc;
      x   = {a[119:0], a[127:120]};
      acc = 8'd0;
      for (int j = 0; j < 16; j++) acc = acc ^ gf_mul(x[8*j +: 8], L_COEF[8*j +: 8]);
      return {a[119:0], acc};
   endfunction

`ifdef KUZ_FAST_LINV_EN
   function automatic logic [BLOCK_W-1:0] l_inv(input logic [BLOCK_W-1:0] a);
      logic [BLOCK_W-1:0] s;
      s = a;
      for (int k = 0; k < 16; k++) s = r_inv(s);
      return s;
   endfunction
`endif

   // Inverse GOST S-box
   function automatic logic [7:0] pi_inv(input logic [7:0] x);
      logic [7:0] r;
      r = 8'd0;
      case (x)
         8'd0: r = 8'd165;   8'd1: r = 8'd45;    8'd2: r = 8'd50;    8'd3: r = 8'd143;   8'd4: r = 8'd14;    8'd5: r = 8'd48;    8'd6: r = 8'd56;    8'd7: r = 8'd192;
         8'd8: r = 8'd84;    8'd9: r = 8'd230;   8'd10: r = 8'd158;  8'd11: r = 8'd57;   8'd12: r = 8'd85;   8'd13: r = 8'd126;  8'd14: r = 8'd82;   8'd15: r = 8'd145;
         8'd16: r = 8'd100;  8'd17: r = 8'd3;    8'd18: r = 8'd87;   8'd19: r = 8'd90;   8'd20: r = 8'd28;   8'd21: r = 8'd96;   8'd22: r = 8'd7;    8'd23: r = 8'd24;
         8'd24: r = 8'd33;   8'd25: r = 8'd114;  8'd26: r = 8'd168;  8'd27: r = 8'd209;  8'd28: r = 8'd41;   8'd29: r = 8'd198;  8'd30: r = 8'd164;  8'd31: r = 8'd63;
         8'd32: r = 8'd224;  8'd33: r = 8'd39;   8'd34: r = 8'd141;  8'd35: r = 8'd12;   8'd36: r = 8'd130;  8'd37: r = 8'd234;  8'd38: r = 8'd174;  8'd39: r = 8'd180;
         8'd40: r = 8'd154;  8'd41: r = 8'd99;   8'd42: r = 8'd73;   8'd43: r = 8'd229;  8'd44: r = 8'd66;   8'd45: r = 8'd228;  8'd46: r = 8'd21;   8'd47: r = 8'd183;
         8'd48: r = 8'd200;  8'd49: r = 8'd6;    8'd50: r = 8'd112;  8'd51: r = 8'd157;  8'd52: r = 8'd65;   8'd53: r = 8'd117;  8'd54: r = 8'd25;   8'd55: r = 8'd201;
         8'd56: r = 8'd170;  8'd57: r = 8'd252;  8'd58: r = 8'd77;   8'd59: r = 8'd191;  8'd60: r = 8'd42;   8'd61: r = 8'd115;  8'd62: r = 8'd132;  8'd63: r = 8'd213;
         8'd64: r = 8'd195;  8'd65: r = 8'd175;  8'd66: r = 8'd43;   8'd67: r = 8'd134;  8'd68: r = 8'd167;  8'd69: r = 8'd177;  8'd70: r = 8'd178;  8'd71: r = 8'd91;
         8'd72: r = 8'd70;   8'd73: r = 8'd211;  8'd74: r = 8'd159;  8'd75: r = 8'd253;  8'd76: r = 8'd212;  8'd77: r = 8'd15;   8'd78: r = 8'd156;  8'd79: r = 8'd47;
         8'd80: r = 8'd155;  8'd81: r = 8'd67;   8'd82: r = 8'd239;  8'd83: r = 8'd217;  8'd84: r = 8'd121;  8'd85: r = 8'd182;  8'd86: r = 8'd83;   8'd87: r = 8'd127;
         8'd88: r = 8'd193;  8'd89: r = 8'd240;  8'd90: r = 8'd35;   8'd91: r = 8'd231;  8'd92: r = 8'd37;   8'd93: r = 8'd94;   8'd94: r = 8'd181;  8'd95: r = 8'd30;
         8'd96: r = 8'd162;  8'd97: r = 8'd223;  8'd98: r = 8'd166;  8'd99: r = 8'd254;  8'd100: r = 8'd172; 8'd101: r = 8'd34;  8'd102: r = 8'd249; 8'd103: r = 8'd226;
         8'd104: r = 8'd74;  8'd105: r = 8'd188; 8'd106: r = 8'd53;  8'd107: r = 8'd202; 8'd108: r = 8'd238; 8'd109: r = 8'd120; 8'd110: r = 8'd5;   8'd111: r = 8'd107;
         8'd112: r = 8'd81;  8'd113: r = 8'd225; 8'd114: r = 8'd89;  8'd115: r = 8'd163; 8'd116: r = 8'd242; 8'd117: r = 8'd113; 8'd118: r = 8'd86;  8'd119: r = 8'd17;
         8'd120: r = 8'd106; 8'd121: r = 8'd137; 8'd122: r = 8'd148; 8'd123: r = 8'd101; 8'd124: r = 8'd140; 8'd125: r = 8'd187; 8'd126: r = 8'd119; 8'd127: r = 8'd60;
         8'd128: r = 8'd123; 8'd129: r = 8'd40;  8'd130: r = 8'd171; 8'd131: r = 8'd210; 8'd132: r = 8'd49;  8'd133: r = 8'd222; 8'd134: r = 8'd196; 8'd135: r = 8'd95;
         8'd136: r = 8'd204; 8'd137: r = 8'd207; 8'd138: r = 8'd118; 8'd139: r = 8'd44;  8'd140: r = 8'd184; 8'd141: r = 8'd216; 8'd142: r = 8'd46;  8'd143: r = 8'd54;
         8'd144: r = 8'd219; 8'd145: r = 8'd105; 8'd146: r = 8'd179; 8'd147: r = 8'd20;  8'd148: r = 8'd149; 8'd149: r = 8'd190; 8'd150: r = 8'd98;  8'd151: r = 8'd161;
         8'd152: r = 8'd59;  8'd153: r = 8'd22;  8'd154: r = 8'd102; 8'd155: r = 8'd233; 8'd156: r = 8'd92;  8'd157: r = 8'd108; 8'd158: r = 8'd109; 8'd159: r = 8'd173;
         8'd160: r = 8'd55;  8'd161: r = 8'd97;  8'd162: r = 8'd75;  8'd163: r = 8'd185; 8'd164: r = 8'd227; 8'd165: r = 8'd186; 8'd166: r = 8'd241; 8'd167: r = 8'd160;
         8'd168: r = 8'd133; 8'd169: r = 8'd131; 8'd170: r = 8'd218; 8'd171: r = 8'd71;  8'd172: r = 8'd197; 8'd173: r = 8'd176; 8'd174: r = 8'd51;  8'd175: r = 8'd250;
         8'd176: r = 8'd150; 8'd177: r = 8'd111; 8'd178: r = 8'd110; 8'd179: r = 8'd194; 8'd180: r = 8'd246; 8'd181: r = 8'd80;  8'd182: r = 8'd255; 8'd183: r = 8'd93;
         8'd184: r = 8'd169; 8'd185: r = 8'd142; 8'd186: r = 8'd23;  8'd187: r = 8'd27;  8'd188: r = 8'd151; 8'd189: r = 8'd125; 8'd190: r = 8'd236; 8'd191: r = 8'd88;
         8'd192: r = 8'd247; 8'd193: r = 8'd31;  8'd194: r = 8'd251; 8'd195: r = 8'd124; 8'd196: r = 8'd9;   8'd197: r = 8'd13;  8'd198: r = 8'd122; 8'd199: r = 8'd103;
         8'd200: r = 8'd69;  8'd201: r = 8'd135; 8'd202: r = 8'd220; 8'd203: r = 8'd232; 8'd204: r = 8'd79;  8'd205: r = 8'd29;  8'd206: r = 8'd78;  8'd207: r = 8'd4;
         8'd208: r = 8'd235; 8'd209: r = 8'd248; 8'd210: r = 8'd243; 8'd211: r = 8'd62;  8'd212: r = 8'd61;  8'd213: r = 8'd189; 8'd214: r = 8'd138; 8'd215: r = 8'd136;
         8'd216: r = 8'd221; 8'd217: r = 8'd205; 8'd218: r = 8'd11;  8'd219: r = 8'd19;  8'd220: r = 8'd152; 8'd221: r = 8'd2;   8'd222: r = 8'd147; 8'd223: r = 8'd128;
         8'd224: r = 8'd144; 8'd225: r = 8'd208; 8'd226: r = 8'd36;  8'd227: r = 8'd52;  8'd228: r = 8'd203; 8'd229: r = 8'd237; 8'd230: r = 8'd244; 8'd231: r = 8'd206;
         8'd232: r = 8'd153; 8'd233: r = 8'd16;  8'd234: r = 8'd68;  8'd235: r = 8'd64;  8'd236: r = 8'd146; 8'd237: r = 8'd58;  8'd238: r = 8'd1;   8'd239: r = 8'd38;
         8'd240: r = 8'd18;  8'd241: r = 8'd26;  8'd242: r = 8'd72;  8'd243: r = 8'd104; 8'd244: r = 8'd245; 8'd245: r = 8'd129; 8'd246: r = 8'd139; 8'd247: r = 8'd199;
         8'd248: r = 8'd214; 8'd249: r = 8'd32;  8'd250: r = 8'd10;  8'd251: r = 8'd8;   8'd252: r = 8'd0;   8'd253: r = 8'd76;  8'd254: r = 8'd215; 8'd255: r = 8'd116;
      endcase
      return r;
   endfunction

   function automatic logic [BLOCK_W-1:0] s_inv(input logic [BLOCK_W-1:0] a);
      logic [BLOCK_W-1:0] s;
      s = '0;
      for (int j = 0; j < 16; j++) s[8*j +: 8] = pi_inv(a[8*j +: 8]);
      return s;
   endfunction

   // Round key for the current SXOR step; keys are read live, never copied
   always_comb begin
      rkey_c = '0;
      case (rnd_q)
         4'd1:    rkey_c = bus.key_1;
         4'd2:    rkey_c = bus.key_2;
         4'd3:    rkey_c = bus.key_3;
         4'd4:    rkey_c = bus.key_4;
         4'd5:    rkey_c = bus.key_5;
         4'd6:    rkey_c = bus.key_6;
         4'd7:    rkey_c = bus.key_7;
         4'd8:    rkey_c = bus.key_8;
         4'd9:    rkey_c = bus.key_9;
         default: rkey_c = '0;
      endcase
   end

   assign sxor_c   = s_inv(st_q) ^ rkey_c;
`ifdef KUZ_FAST_LINV_EN
   assign linv_c   = l_inv(st_q);
`else
   assign linv_c   = r_inv(st_q);
`endif
   assign key_ok_c = (CHECK_KEYS == 0) || bus.keys_valid;
   assign abort_c  = (CHECK_KEYS != 0) && !bus.keys_valid && (state_q != IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         st_q       <= '0;
         rnd_q      <= '0;
         step_q     <= '0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         st_q       <= st_d;
         rnd_q      <= rnd_d;
         step_q     <= step_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         data_out_q <= data_out_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      st_d       = st_q;
      rnd_d      = rnd_q;
      step_d     = step_q;
      ready_d    = ready_q;
      done_d     = 1'b0;
      data_out_d = data_out_q;

      unique case (state_q)
         IDLE: begin
            // ready comes back one cycle after done, so a start during done is dropped
            ready_d = 1'b1;
            if (bus.start && ready_q && key_ok_c) begin
               st_d    = bus.data_in ^ bus.key_10;
               rnd_d   = 4'd9;
               step_d  = '0;
               ready_d = 1'b0;
               state_d = LINV;
            end
         end
         LINV: begin
            st_d = linv_c;
`ifdef KUZ_FAST_LINV_EN
            state_d = SXOR;
`else
            if (step_q == 4'd15) state_d = SXOR;
            else                 step_d  = step_q + 4'd1;
`endif
         end
         SXOR: begin
            st_d   = sxor_c;
            step_d = '0;
            if (rnd_q > 4'd1) begin
               rnd_d   = rnd_q - 4'd1;
               state_d = LINV;
            end else begin
               rnd_d      = '0;
               data_out_d = sxor_c;
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Keys withdrawn mid-block: drop the work, keep the previous plaintext
      if (abort_c) begin
         state_d    = IDLE;
         st_d       = '0;
         rnd_d      = '0;
         step_d     = '0;
         ready_d    = 1'b1;
         done_d     = 1'b0;
         data_out_d = data_out_q;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.done     = done_q;
   assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_kuznechik_decrypt_core.sv
// Self-checking bench for kuznechik_decrypt_core. Expected plaintexts come from a
// forward Kuznechik model (key schedule + encryption): a random block is encrypted
// here and the DUT must return it.
module tb_kuznechik_decrypt_core;
`ifdef KUZ_FAST_LINV_EN
   localparam int EXP_LAT = 19;
`else
   localparam int EXP_LAT = 154;
`endif
   localparam int ABORT_AT = (EXP_LAT > 40) ? 30 : 8;
   localparam int RESET_AT = (EXP_LAT > 80) ? 60 : 10;
   localparam int LIMIT    = 400;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   kuznechik_decrypt_core_if bus ();

   kuznechik_decrypt_core #(.CHECK_KEYS(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   int unsigned pi_tab [256] = '{
      252, 238, 221, 17, 207, 110, 49, 22, 251, 196, 250, 218, 35, 197, 4, 77,
      233, 119, 240, 219, 147, 46, 153, 186, 23, 54, 241, 187, 20, 205, 95, 193,
      249, 24, 101, 90, 226, 92, 239, 33, 129, 28, 60, 66, 139, 1, 142, 79,
      5, 132, 2, 174, 227, 106, 143, 160, 6, 11, 237, 152, 127, 212, 211, 31,
      235, 52, 44, 81, 234, 200, 72, 171, 242, 42, 104, 162, 253, 58, 206, 204,
      181, 112, 14, 86, 8, 12, 118, 18, 191, 114, 19, 71, 156, 183, 93, 135,
      21, 161, 150, 41, 16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
      50, 117, 25, 61, 255, 53, 138, 126, 109, 84, 198, 128, 195, 189, 13, 87,
      223, 245, 36, 169, 62, 168, 67, 201, 215, 121, 214, 246, 124, 34, 185, 3,
      224, 15, 236, 222, 122, 148, 176, 188, 220, 232, 40, 80, 78, 51, 10, 74,
      167, 151, 96, 115, 30, 0, 98, 68, 26, 184, 56, 130, 100, 159, 38, 65,
      173, 69, 70, 146, 39, 94, 85, 47, 140, 163, 165, 125, 105, 213, 149, 59,
      7, 88, 179, 64, 134, 172, 29, 247, 48, 55, 107, 228, 136, 217, 231, 137,
      225, 27, 131, 73, 76, 63, 248, 254, 141, 83, 170, 144, 202, 216, 133, 97,
      32, 113, 103, 164, 45, 43, 9, 91, 203, 155, 37, 208, 190, 229, 108, 82,
      89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194, 57, 75, 99, 182};
   // l() weight of byte a_j (a0 = least significant byte)
   int unsigned lc_tab [16] = '{1, 148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148};

   logic [127:0] rk [1:10];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Polynomial product then reduction by 0x1C3
   function automatic int unsigned gmul(input int unsigned a, input int unsigned b);
      int unsigned p;
      p = 0;
      for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
      for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ (32'h1C3 << (i - 8));
      return p;
   endfunction

   // L = R^16, R(a15..a0) = l(a15..a0) || a15..a1
   function automatic logic [127:0] lin(input logic [127:0] a);
      logic [127:0] s;
      int unsigned  acc;
      s = a;
      for (int r = 0; r < 16; r++) begin
         acc = 0;
         for (int j = 0; j < 16; j++) acc = acc ^ gmul(32'(s[8*j +: 8]), lc_tab[j]);
         s = {8'(acc), s[127:8]};
      end
      return s;
   endfunction

   function automatic logic [127:0] sub(input logic [127:0] a);
      logic [127:0] s;
      for (int j = 0; j < 16; j++) s[8*j +: 8] = 8'(pi_tab[a[8*j +: 8]]);
      return s;
   endfunction

   task automatic expand_keys(input logic [255:0] mk);
      logic [127:0] a1, a0, t, c;
      rk[1] = mk[255:128];
      rk[2] = mk[127:0];
      a1 = rk[1];
      a0 = rk[2];
      for (int i = 1; i <= 4; i++) begin
         for (int j = 1; j <= 8; j++) begin
            c  = lin(128'(8 * (i - 1) + j));
            t  = lin(sub(a1 ^ c)) ^ a0;
            a0 = a1;
            a1 = t;
         end
         rk[2*i+1] = a1;
         rk[2*i+2] = a0;
      end
      bus.key_1 = rk[1]; bus.key_2 = rk[2]; bus.key_3 = rk[3]; bus.key_4 = rk[4];
      bus.key_5 = rk[5]; bus.key_6 = rk[6]; bus.key_7 = rk[7]; bus.key_8 = rk[8];
      bus.key_9 = rk[9]; bus.key_10 = rk[10];
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] p);
      logic [127:0] a;
      a = p;
      for (int i = 1; i <= 9; i++) a = lin(sub(a ^ rk[i]));
      return a ^ rk[10];
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic pulse_start(input logic [127:0] c);
      bus.data_in = c;
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.start   = 1'b0;
   endtask

   // Cycle count includes the accepting edge; returns in the done cycle
   task automatic wait_done(input int lat0, output int lat, output logic rdy_hi);
      lat    = lat0;
      rdy_hi = 1'b0;
      while (!bus.done && lat < LIMIT) begin
         if (bus.ready) rdy_hi = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      if (bus.ready) rdy_hi = 1'b1;
   endtask

   task automatic finish_checks(input string tag, input int lat, input logic rdy_hi, input logic [127:0] exp);
      check({tag, "_done"}, 128'(bus.done), 128'(1));
      check({tag, "_pt"}, bus.data_out, exp);
      check({tag, "_lat"}, 128'(lat), 128'(EXP_LAT));
      check({tag, "_rdy_low"}, 128'(rdy_hi), 128'(0));
   endtask

   task automatic decrypt_and_check(input string tag, input logic [127:0] c, input logic [127:0] exp);
      int   lat;
      logic rdy_hi;
      pulse_start(c);
      wait_done(1, lat, rdy_hi);
      finish_checks(tag, lat, rdy_hi, exp);
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1'b1;
      end
      check(tag, 128'(seen), 128'(0));
   endtask

   localparam logic [255:0] GOST_KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
   localparam logic [127:0] GOST_CT  = 128'h7f679d90bebc24305a468d42b9d4edcd;
   localparam logic [127:0] GOST_PT  = 128'h1122334455667700ffeeddccbbaa9988;

   initial begin
      logic [127:0] p, c, prev;
      int           lat;
      logic         rdy_hi;

      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.data_in    = '0;
      bus.keys_valid = 1'b0;
      expand_keys(GOST_KEY);
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 128'(bus.ready), 128'(1));
      check("rst_done", 128'(bus.done), 128'(0));
      check("rst_dout", bus.data_out, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // keys not valid: start ignored
      pulse_start(GOST_CT);
      check("nokey_ready", 128'(bus.ready), 128'(1));
      watch_no_done("nokey_no_done", EXP_LAT + 10);
      bus.keys_valid = 1'b1;

      // reference vector, then single-cycle done and ready return
      decrypt_and_check("gost", GOST_CT, GOST_PT);
      @(posedge clk); #1;
      check("gost_done_pulse", 128'(bus.done), 128'(0));
      check("gost_ready_back", 128'(bus.ready), 128'(1));

      // back-to-back one cycle after done
      decrypt_and_check("b2b", GOST_CT, GOST_PT);

      // start during the done cycle is dropped
      pulse_start(rnd128());
      check("donecyc_ready", 128'(bus.ready), 128'(1));
      watch_no_done("donecyc_no_done", EXP_LAT + 10);
      check("donecyc_dout", bus.data_out, GOST_PT);

      // reset in the middle of a block
      pulse_start(GOST_CT);
      repeat (RESET_AT - 1) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 128'(bus.ready), 128'(1));
      check("midrst_done", 128'(bus.done), 128'(0));
      check("midrst_dout", bus.data_out, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      decrypt_and_check("postrst", GOST_CT, GOST_PT);
      @(posedge clk); #1;

      // keys withdrawn mid-block
      prev = GOST_PT;
      pulse_start(rnd128());
      repeat (ABORT_AT - 1) @(posedge clk);
      #1;
      bus.keys_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_ready", 128'(bus.ready), 128'(1));
      check("abort_done", 128'(bus.done), 128'(0));
      bus.keys_valid = 1'b1;
      watch_no_done("abort_no_done", EXP_LAT + 10);
      check("abort_dout", bus.data_out, prev);

      // second start while busy is ignored
      p = rnd128();
      c = encrypt(p);
      pulse_start(c);
      repeat (8) @(posedge clk);
      #1;
      pulse_start(rnd128());
      wait_done(10, lat, rdy_hi);
      finish_checks("busy_start", lat, rdy_hi, p);
      @(posedge clk); #1;

      // random keys and blocks
      for (int n = 0; n < 6; n++) begin
         expand_keys({rnd128(), rnd128()});
         p = rnd128();
         c = encrypt(p);
         decrypt_and_check($sformatf("rand%0d", n), c, p);
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
